// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
// The requester holds the master side; the adder holds the slave side.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow, zero
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow, zero
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a small ripple
// chain and one carry register; result and flags held until the next start.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q, done_q;

    assign last = (cnt == CW'(STEPS - 1));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_reg[i] ^ b_reg[i] ^ c[i];
            c[i + 1] = (a_reg[i] & b_reg[i]) | (c[i] & (a_reg[i] ^ b_reg[i]));
        end
        // New digit enters at the MSB end; after STEPS shifts the LSB digit sits at bit 0.
        res_next = (res_reg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    res_reg <= res_next;
                    carry   <= c[DIGIT];
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        sum_q  <= res_next;
                        cout_q <= c[DIGIT];
                        ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
                        zero_q <= (res_next == '0);
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table on three 16-bit digit sizes,
// handshake/abort sequences, and random vectors against a reference model.
module tb_serial_adder;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic        s_start, s_cin, s_sub;
    logic [15:0] s_a, s_b;

    serial_adder_if #(.WIDTH(16)) if_main ();
    serial_adder_if #(.WIDTH(16)) if_d4 ();
    serial_adder_if #(.WIDTH(16)) if_d16 ();
    serial_adder_if #(.WIDTH(8))  if_r8 ();
    serial_adder_if #(.WIDTH(32)) if_r32 ();

    assign if_main.start = s_start; assign if_main.a = s_a; assign if_main.b = s_b;
    assign if_main.cin   = s_cin;   assign if_main.sub = s_sub;
    assign if_d4.start   = s_start; assign if_d4.a = s_a;   assign if_d4.b = s_b;
    assign if_d4.cin     = s_cin;   assign if_d4.sub = s_sub;
    assign if_d16.start  = s_start; assign if_d16.a = s_a;  assign if_d16.b = s_b;
    assign if_d16.cin    = s_cin;   assign if_d16.sub = s_sub;

    serial_adder #(.WIDTH(16), .DIGIT(1))  dut_main (.clock(clock), .reset_n(reset_n), .bus(if_main));
    serial_adder #(.WIDTH(16), .DIGIT(4))  dut_d4   (.clock(clock), .reset_n(reset_n), .bus(if_d4));
    serial_adder #(.WIDTH(16), .DIGIT(16)) dut_d16  (.clock(clock), .reset_n(reset_n), .bus(if_d16));
    serial_adder #(.WIDTH(8),  .DIGIT(2))  dut_r8   (.clock(clock), .reset_n(reset_n), .bus(if_r8));
    serial_adder #(.WIDTH(32), .DIGIT(8))  dut_r32  (.clock(clock), .reset_n(reset_n), .bus(if_r32));

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Packed as {zero, overflow, cout, sum}; subtraction flags derived from a-b directly.
    function automatic logic [34:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        logic [63:0] mask, aa, bb, full, r;
        logic        co, ov, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(a) & mask;
        bb   = 64'(b) & mask;
        if (sub) begin
            full = aa - bb;
            co   = (aa >= bb);
        end else begin
            full = aa + bb + 64'(cin);
            co   = full[w];
        end
        r  = full & mask;
        sa = aa[w-1];
        sb = bb[w-1];
        sr = r[w-1];
        ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {(r == 64'd0), ov, co, r[31:0]};
    endfunction

    // Latencies count negedges after the accept edge; -1 means no done seen.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts,
                          output int lat1, output int lat4, output int lat16, output int busy1);
        @(negedge clock);
        s_a = ta; s_b = tb_v; s_cin = tc; s_sub = ts; s_start = 1'b1;
        lat1 = -1; lat4 = -1; lat16 = -1; busy1 = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (j == 0) s_start = 1'b0;
            if (if_d16.done && lat16 < 0) lat16 = j;
            if (if_d4.done && lat4 < 0) lat4 = j;
            if (if_main.done) begin
                lat1 = j;
                break;
            end
            busy1 += int'(if_main.busy);
        end
    endtask

    initial begin
        int          lat1, lat4, lat16, busy1, lat;
        logic        bad;
        logic [34:0] exp;
        logic [15:0] ra, rb;
        logic [7:0]  a8, b8;
        logic [31:0] a32, b32;
        logic        rc, rs, seen;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

        s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        if_r8.start = 1'b0;  if_r8.a = '0;  if_r8.b = '0;  if_r8.cin = 1'b0;  if_r8.sub = 1'b0;
        if_r32.start = 1'b0; if_r32.a = '0; if_r32.b = '0; if_r32.cin = 1'b0; if_r32.sub = 1'b0;
        reset_n = 1'b0;

        // Reset state and idle hold
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({if_main.busy, if_main.done, if_main.sum, if_main.cout,
                                    if_main.overflow, if_main.zero}), 64'd0);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (if_main.busy || if_main.done || if_main.sum != 16'd0 || if_main.zero ||
                if_main.cout || if_main.overflow) bad = 1'b1;
        end
        check("idle_hold", 64'(bad), 64'd0);

        // Directed vector table on DIGIT=1, 4, 16
        for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat1, lat4, lat16, busy1);
            e = 64'({vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
            check($sformatf("vec%0d_d1_result", i),
                  64'({if_main.sum, if_main.cout, if_main.overflow, if_main.zero}), e);
            check($sformatf("vec%0d_d4_result", i),
                  64'({if_d4.sum, if_d4.cout, if_d4.overflow, if_d4.zero}), e);
            check($sformatf("vec%0d_d16_result", i),
                  64'({if_d16.sum, if_d16.cout, if_d16.overflow, if_d16.zero}), e);
            check($sformatf("vec%0d_d1_latency", i), 64'(lat1), 64'd16);
            check($sformatf("vec%0d_d1_busy_cycles", i), 64'(busy1), 64'd16);
            check($sformatf("vec%0d_d4_latency", i), 64'(lat4), 64'd4);
            check($sformatf("vec%0d_d16_latency", i), 64'(lat16), 64'd1);
            @(negedge clock);
            check($sformatf("vec%0d_done_one_cycle", i), 64'(if_main.done), 64'd0);
            check($sformatf("vec%0d_sum_hold", i), 64'(if_main.sum), 64'(vecs[i].sum));
        end

        // start held high, operands changed after accept, second accept on the done cycle
        @(negedge clock);
        s_a = 16'h1234; s_b = 16'h0FCD; s_cin = 1'b1; s_sub = 1'b0; s_start = 1'b1;
        @(negedge clock);
        s_a = 16'h0001; s_b = 16'h0002; s_cin = 1'b0;
        lat = -1;
        for (int j = 1; j < 40; j++) begin
            @(negedge clock);
            if (j == 8) begin
                check("sum_held_during_run", 64'(if_main.sum), 64'h0001);
                check("busy_mid_run", 64'(if_main.busy), 64'd1);
            end
            if (if_main.done) begin
                lat = j;
                break;
            end
        end
        check("held_start_latency", 64'(lat), 64'd16);
        check("held_start_result", 64'({if_main.sum, if_main.cout, if_main.overflow}), 64'({16'h2202, 2'b00}));
        lat = -1;
        for (int j = 1; j < 40; j++) begin
            @(negedge clock);
            if (j == 1) begin
                s_start = 1'b0;
                check("second_accept_busy", 64'(if_main.busy), 64'd1);
            end
            if (if_main.done) begin
                lat = j;
                break;
            end
        end
        check("back_to_back_spacing", 64'(lat), 64'd17);
        check("second_result", 64'({if_main.sum, if_main.cout, if_main.zero}), 64'({16'h0003, 2'b00}));

        // Reset asserted at cycle 8 of RUN
        @(negedge clock);
        s_a = 16'hFFFF; s_b = 16'h0001; s_cin = 1'b0; s_sub = 1'b0; s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_busy_before", 64'(if_main.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", 64'({if_main.busy, if_main.done, if_main.sum, if_main.cout,
                                   if_main.overflow, if_main.zero}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (if_main.done || if_main.busy || if_main.sum != 16'd0) bad = 1'b1;
        end
        check("abort_no_done", 64'(bad), 64'd0);

        // Random vectors, WIDTH=16 on all three digit sizes
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            exp = ref_model(16, 32'(ra), 32'(rb), rc, rs);
            run_op(ra, rb, rc, rs, lat1, lat4, lat16, busy1);
            check("rand_w16_d1_latency", 64'(lat1), 64'd16);
            check("rand_w16_d1", 64'({if_main.zero, if_main.overflow, if_main.cout, 32'(if_main.sum)}), 64'(exp));
            check("rand_w16_d4", 64'({if_d4.zero, if_d4.overflow, if_d4.cout, 32'(if_d4.sum)}), 64'(exp));
            check("rand_w16_d16", 64'({if_d16.zero, if_d16.overflow, if_d16.cout, 32'(if_d16.sum)}), 64'(exp));
        end

        // Random vectors, WIDTH=8
        for (int k = 0; k < 1000; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            exp = ref_model(8, 32'(a8), 32'(b8), rc, rs);
            @(negedge clock);
            if_r8.a = a8; if_r8.b = b8; if_r8.cin = rc; if_r8.sub = rs; if_r8.start = 1'b1;
            @(negedge clock);
            if_r8.start = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (if_r8.done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            check("rand_w8", seen ? 64'({if_r8.zero, if_r8.overflow, if_r8.cout, 32'(if_r8.sum)}) : '1, 64'(exp));
        end

        // Random vectors, WIDTH=32
        for (int k = 0; k < 1000; k++) begin
            a32 = $urandom; b32 = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            exp = ref_model(32, a32, b32, rc, rs);
            @(negedge clock);
            if_r32.a = a32; if_r32.b = b32; if_r32.cin = rc; if_r32.sub = rs; if_r32.start = 1'b1;
            @(negedge clock);
            if_r32.start = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (if_r32.done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            check("rand_w32", seen ? 64'({if_r32.zero, if_r32.overflow, if_r32.cout, if_r32.sum}) : '1, 64'(exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
